// File: rtl/fcmp_pipe.sv
// fcmp_pipe: IEEE-754 single-precision compare (feq/flt/fle) with a valid/ready pipeline.
// Latency: 2 cycles from acceptance to out_valid; one request per cycle when out_ready is held high.
// Backpressure: out_ready low freezes S2 and then S1, in_ready drops once both stages hold work.
module fcmp_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        nv
);

    // Operand classification carried from S1 to S2.
    typedef struct packed {
        logic [1:0] op;
        logic       nan;        // either operand is NaN
        logic       snan;       // either operand is signalling NaN
        logic       both_zero;  // +0/-0 in any combination
        logic       bit_eq;     // bitwise identical encodings
        logic       lt;         // x1 < x2 in sign-magnitude order (NaNs ignored)
    } meta_t;

    localparam logic [1:0] OP_FEQ = 2'b00;
    localparam logic [1:0] OP_FLT = 2'b01;
    localparam logic [1:0] OP_FLE = 2'b10;

    logic  s1_valid;
    meta_t s1_meta;
    logic  s2_valid;
    logic  s2_res;
    logic  s2_nv;

    logic  s2_adv;
    logic  nan1, nan2, snan1, snan2, zero1, zero2;
    logic  mag_lt, mag_gt, both_zero, lt_c;
    meta_t meta_c;
    logic  res_c, nv_c;

    // S2 frees up when empty or when its result is being taken; S1 only moves when S2 does.
    assign s2_adv   = !s2_valid || out_ready;
    assign in_ready = rstn && (!s1_valid || s2_adv);

    assign nan1      = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
    assign nan2      = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
    assign snan1     = nan1 && !x1[22];
    assign snan2     = nan2 && !x2[22];
    assign zero1     = (x1[30:0] == 31'd0);
    assign zero2     = (x2[30:0] == 31'd0);
    assign both_zero = zero1 && zero2;
    assign mag_lt    = (x1[30:0] < x2[30:0]);
    assign mag_gt    = (x1[30:0] > x2[30:0]);

    // Sign-magnitude ordering: negative below positive unless both are zero; negative magnitudes invert.
    always_comb begin
        lt_c = 1'b0;
        if (x1[31] != x2[31]) begin
            lt_c = x1[31] && !both_zero;
        end else if (x1[31]) begin
            lt_c = mag_gt;
        end else begin
            lt_c = mag_lt;
        end
    end

    // Pack the S1 classification of the incoming request.
    always_comb begin
        meta_c           = '0;
        meta_c.op        = op;
        meta_c.nan       = nan1 || nan2;
        meta_c.snan      = snan1 || snan2;
        meta_c.both_zero = both_zero;
        meta_c.bit_eq    = (x1 == x2);
        meta_c.lt        = lt_c;
    end

    // Resolve the compare result and invalid flag from the S1 classification.
    always_comb begin
        res_c = 1'b0;
        nv_c  = 1'b0;
        case (s1_meta.op)
            OP_FEQ: begin
                res_c = !s1_meta.nan && (s1_meta.bit_eq || s1_meta.both_zero);
                nv_c  = s1_meta.snan;
            end
            OP_FLT: begin
                res_c = !s1_meta.nan && s1_meta.lt;
                nv_c  = s1_meta.nan;
            end
            OP_FLE: begin
                res_c = !s1_meta.nan && (s1_meta.lt || s1_meta.bit_eq || s1_meta.both_zero);
                nv_c  = s1_meta.nan;
            end
            default: begin
                res_c = 1'b0;
                nv_c  = 1'b0;
            end
        endcase
    end

    // Pipeline registers; reset drops all in-flight work and clears the visible result.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_meta  <= '0;
            s2_valid <= 1'b0;
            s2_res   <= 1'b0;
            s2_nv    <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_res <= res_c;
                    s2_nv  <= nv_c;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_meta <= meta_c;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign y         = {31'd0, s2_res};
    assign nv        = s2_nv;

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: directed vectors for fcmp_pipe, scoreboarded against an ordered-key compare model.
// Latency: expects results 2 cycles after acceptance with out_ready high.
// Backpressure: exercises a full stall, in_ready drop, result hold and drain.
module tb_fcmp_pipe;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        nv;

    int checks   = 0;
    int failures = 0;
    int consumed = 0;

    logic [1:0] sbq[$];
    logic       stall_prev = 1'b0;
    logic [31:0] prev_y = '0;
    logic        prev_nv = 1'b0;

    fcmp_pipe dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .nv(nv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: map each non-NaN value onto a signed integer that orders like the real number.
    function automatic longint fkey(input logic [31:0] a);
        longint m;
        m = longint'(a[30:0]);
        return a[31] ? -m : m;
    endfunction

    function automatic logic is_nan(input logic [31:0] a);
        return (a[30:23] == 8'hFF) && (a[22:0] != 0);
    endfunction

    // Returns {nv, result}.
    function automatic logic [1:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic anynan, anysnan, r, v;
        anynan  = is_nan(a) || is_nan(b);
        anysnan = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
        r = 1'b0;
        v = 1'b0;
        case (o)
            2'd0: begin r = !anynan && (fkey(a) == fkey(b)); v = anysnan; end
            2'd1: begin r = !anynan && (fkey(a) <  fkey(b)); v = anynan; end
            2'd2: begin r = !anynan && (fkey(a) <= fkey(b)); v = anynan; end
            default: begin r = 1'b0; v = 1'b0; end
        endcase
        return {v, r};
    endfunction

    // Directed vectors with hand-computed {nv, result}.
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  exp;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV] = '{
        '{2'd0, 32'h3F800000, 32'h3F800000, 2'b01},  // feq 1.0 == 1.0
        '{2'd0, 32'h00000000, 32'h80000000, 2'b01},  // feq +0 == -0
        '{2'd1, 32'h00000000, 32'h80000000, 2'b00},  // flt +0 < -0 false
        '{2'd2, 32'h00000000, 32'h80000000, 2'b01},  // fle +0 <= -0
        '{2'd0, 32'h7FA00000, 32'h3F800000, 2'b10},  // feq sNaN
        '{2'd0, 32'h7FC00000, 32'h3F800000, 2'b00},  // feq qNaN quiet
        '{2'd1, 32'h7FC00000, 32'h3F800000, 2'b10},  // flt qNaN signals
        '{2'd1, 32'hC0000000, 32'hBF800000, 2'b01},  // -2 < -1
        '{2'd1, 32'hFF800000, 32'h7F800000, 2'b01},  // -inf < +inf
        '{2'd2, 32'h7F800000, 32'h7F800000, 2'b01},  // +inf <= +inf
        '{2'd3, 32'h3F800000, 32'h3F800000, 2'b00},  // reserved op
        '{2'd1, 32'h00000001, 32'h00000002, 2'b01},  // denormals ordered
        '{2'd1, 32'h80000002, 32'h80000001, 2'b01},  // negative denormals
        '{2'd2, 32'h40000000, 32'h3F800000, 2'b00},  // 2 <= 1 false
        '{2'd1, 32'h3F800000, 32'hC0000000, 2'b00},  // 1 < -2 false
        '{2'd2, 32'h7F800001, 32'h00000000, 2'b10},  // fle sNaN
        '{2'd0, 32'h3F800000, 32'hBF800000, 2'b00},  // 1 == -1 false
        '{2'd1, 32'h80000000, 32'h00000000, 2'b00}   // -0 < +0 false
    };

    // Scoreboard compare: every consumed result against the model, plus hold-while-stalled.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rstn) begin
            sbq.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_y", y, prev_y);
                check("hold_nv", {31'd0, nv}, {31'd0, prev_nv});
            end
            if (out_valid && out_ready) begin
                consumed++;
                check("sb_has_entry", {31'd0, sbq.size() > 0}, 32'd1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("sb_y", y, {31'd0, e[0]});
                    check("sb_nv", {31'd0, nv}, {31'd0, e[1]});
                end
            end
            if (in_valid && in_ready) sbq.push_back(model(op, x1, x2));
            stall_prev = out_valid && !out_ready;
            prev_y  = y;
            prev_nv = nv;
        end
    end

    task automatic drive(input int i);
        op = vecs[i].op; x1 = vecs[i].a; x2 = vecs[i].b;
        in_valid = 1'b1;
    endtask

    // Hold a request until accepted, bounded.
    task automatic send(input int i);
        int n;
        drive(i);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() > 0 || out_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", {31'd0, n < 50}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [31:0] y_hold;
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'd0; x1 = '0; x2 = '0;

        // Pin the model against hand-computed results.
        for (int i = 0; i < NV; i++)
            check($sformatf("model_v%0d", i), {30'd0, model(vecs[i].op, vecs[i].a, vecs[i].b)}, {30'd0, vecs[i].exp});

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_nv", {31'd0, nv}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Latency: 1.0 feq 1.0 appears exactly two cycles after acceptance.
        drive(0);
        @(negedge clk);
        check("lat_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_c1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_c2_valid", {31'd0, out_valid}, 32'd1);
        check("lat_c2_y", y, 32'h00000001);
        check("lat_c2_nv", {31'd0, nv}, 32'd0);
        @(posedge clk); #1;
        drain();

        // Back-to-back stream of every vector: no bubbles.
        c0 = consumed;
        for (int i = 0; i < NV; i++) begin
            drive(i);
            @(negedge clk);
            check("no_bubble", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        check("stream_count", consumed - c0, NV);

        // Backpressure: four requests with out_ready low.
        out_ready = 1'b0;
        c0 = consumed;
        send(7);
        send(8);
        drive(9);
        @(negedge clk);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_first_y", y, 32'h00000001);
        y_hold = y;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_y_stable", y, y_hold);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(9);
        send(13);
        drain();
        check("bp_count", consumed - c0, 32'd4);

        // Reset with two requests in flight.
        send(0);
        send(4);
        rstn = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_y", y, 32'd0);
        check("midrst_nv", {31'd0, nv}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("midrst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        check("sb_empty_end", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fcmp_pipe.md
FCMP_PIPE -- requirements
Module: fcmp_pipe

Interface
REQ-001 SHALL have clock port clk: input, 1 bit; all state updates on its rising edge.
REQ-002 SHALL have reset port rstn: input, 1 bit; reset is synchronous and active-low.
REQ-003 SHALL have in_valid: input, 1 bit; upstream request present.
REQ-004 SHALL have in_ready: output, 1 bit; block accepts a request this cycle.
REQ-005 SHALL have op: input, 2 bits; 00 feq, 01 flt, 10 fle, 11 reserved.
REQ-006 SHALL have x1, x2: input, 32 bits each; IEEE-754 single operands {sign, exp[7:0], man[22:0]}.
REQ-007 SHALL have out_valid: output, 1 bit; result present.
REQ-008 SHALL have out_ready: input, 1 bit; downstream accepts the result this cycle.
REQ-009 SHALL have y: output, 32 bits; {31'b0, result bit}.
REQ-010 SHALL have nv: output, 1 bit; invalid-operation flag paired with y.

Function
REQ-011 SHALL treat a request as accepted in a cycle where in_valid && in_ready, and a result as consumed where out_valid && out_ready.
REQ-012 SHALL be a 2-stage pipeline: S1 registers operand classification (NaN, sNaN, zero, sign-magnitude less/equal) and op; S2 registers y and nv.
REQ-013 SHALL deliver an accepted request at out_valid exactly 2 cycles after acceptance when out_ready is held high.
REQ-014 SHALL sustain one request per cycle with no bubbles when out_ready is held high.
REQ-015 SHALL advance S2 when !s2_valid || out_ready, and advance S1 into S2 only when S2 advances.
REQ-016 SHALL drive in_ready = !s1_valid || (S2 advancing); in_ready SHALL be combinational from internal state and out_ready only, never from in_valid.
REQ-017 SHALL hold y, nv and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL accept a new request in the same cycle the result is consumed (full pipe, out_ready=1), with no loss or duplication.
REQ-019 SHALL classify NaN as exp==255 && man!=0, and sNaN as NaN && man[22]==0.
REQ-020 SHALL treat +0 and -0 (exp==0, man==0) as equal for all ops.
REQ-021 feq: result = 1 iff neither operand is NaN and (x1==x2 bitwise or both are zero); nv = 1 iff either operand is sNaN.
REQ-022 flt: result = 1 iff neither operand is NaN and x1 < x2 in IEEE order; nv = 1 iff either operand is NaN (quiet or signalling).
REQ-023 fle: result = 1 iff neither operand is NaN and x1 <= x2; nv as flt.
REQ-024 SHALL order non-NaN values by sign-magnitude: opposite signs give negative < positive unless both are zero; same sign compares {exp, man} unsigned, inverted when the sign is 1; infinities follow the same rule.
REQ-025 SHALL treat denormals as ordinary magnitudes (no flush).
REQ-026 op=11 SHALL produce y=0 and nv=0 with normal pipeline timing.

Reset
REQ-027 While rstn==0 at a rising edge, SHALL clear s1_valid, s2_valid, out_valid, y (0x00000000) and nv (0).
REQ-028 SHALL drive in_ready=0 while rstn==0 and in_ready=1 on the first cycle after reset.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight requests; no result for them SHALL appear after reset.

Verification
REQ-030 feq x1=0x3F800000, x2=0x3F800000, out_ready=1 -> 2 cycles later out_valid=1, y=0x00000001, nv=0.
REQ-031 feq x1=0x00000000, x2=0x80000000 -> y=1, nv=0; flt with the same operands -> y=0; fle -> y=1.
REQ-032 feq x1=0x7FA00000 (sNaN), x2=0x3F800000 -> y=0, nv=1; feq x1=0x7FC00000 (qNaN) -> y=0, nv=0; flt with the qNaN -> y=0, nv=1.
REQ-033 flt x1=0xC0000000 (-2), x2=0xBF800000 (-1) -> y=1; flt x1=0xFF800000 (-inf), x2=0x7F800000 (+inf) -> y=1; fle x1=0x7F800000, x2=0x7F800000 -> y=1.
REQ-034 Backpressure: issue 4 back-to-back requests with out_ready=0 -> pipe fills after 2 accepts, in_ready=0, y held stable; raise out_ready -> all 4 results in order, one per cycle, none lost or duplicated.
REQ-035 Assert rstn=0 for 1 cycle with 2 requests in flight -> out_valid=0, y=0, nv=0 on the next cycle; no stale result appears afterward.
